// File: rtl/uart_console_tx.sv
// Memory-mapped console transmitter: a store to BASE_ADDRESS queues one character in a small
// FIFO, and a 8N1 serializer drains it; BASE_ADDRESS+4 reads back {overflow, full, idle}.
`timescale 1ns/1ps

`ifndef WRITE
`define WRITE 1'b1
`endif
`ifndef READ
`define READ 1'b0
`endif

// state | meaning
// IDLE  | line high, waiting for a queued character
// START | start bit (line low), CLKS_PER_BIT cycles
// DATA  | 8 data bits LSB first, CLKS_PER_BIT cycles each
// STOP  | stop bit (line high); pops straight into START if more is queued
module uart_console_tx #(
    parameter logic [31:0] BASE_ADDRESS = 32'h1000_0000,
    parameter int          CLKS_PER_BIT = 16,
    parameter int          FIFO_DEPTH   = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        data_memory_interface_enable,
    input  logic        data_memory_interface_state,
    input  logic [31:0] data_memory_interface_address,
    input  logic [3:0]  data_memory_interface_frame_mask,
    input  logic [31:0] data_memory_interface_write_data,
    output logic [31:0] data_memory_interface_read_data,
    output logic        uart_tx,
    output logic        busy
);

    localparam int              AW             = $clog2(FIFO_DEPTH);
    localparam int              BW             = $clog2(CLKS_PER_BIT);
    localparam logic [BW-1:0]   BAUD_MAX       = BW'(CLKS_PER_BIT - 1);
    localparam logic [31:0]     STATUS_ADDRESS = BASE_ADDRESS + 32'd4;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t         r_state;
    state_t         w_state_next;
    logic [BW-1:0]  r_baud;
    logic [BW-1:0]  w_baud_next;
    logic [2:0]     r_bit_idx;
    logic [2:0]     w_bit_idx_next;
    logic [7:0]     r_shift;
    logic [7:0]     w_shift_next;
    logic           r_tx;
    logic           w_tx_next;
    logic           w_pop;

    logic [7:0]     r_mem [FIFO_DEPTH];
    logic [AW:0]    r_wptr;
    logic [AW:0]    r_rptr;
    logic           w_empty;
    logic           w_full;
    logic           w_push_req;
    logic           w_push_ok;

    logic           r_overflow;
    logic [31:0]    r_rdata;
    logic           w_rd_status;
    logic           w_rd_data;
    logic           w_tx_idle;
    logic           w_unused_bits;

    assign w_unused_bits = ^{data_memory_interface_write_data[31:8],
                             data_memory_interface_frame_mask[2:0]};

    assign w_push_req  = data_memory_interface_enable
                       && (data_memory_interface_state == `WRITE)
                       && (data_memory_interface_address == BASE_ADDRESS)
                       && data_memory_interface_frame_mask[3];
    assign w_rd_status = data_memory_interface_enable
                       && (data_memory_interface_state == `READ)
                       && (data_memory_interface_address == STATUS_ADDRESS);
    assign w_rd_data   = data_memory_interface_enable
                       && (data_memory_interface_state == `READ)
                       && (data_memory_interface_address == BASE_ADDRESS);

    // Extra pointer MSB distinguishes full from empty when the index bits match.
    assign w_empty   = (r_wptr == r_rptr);
    assign w_full    = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign w_push_ok = w_push_req && (!w_full || w_pop);
    assign w_tx_idle = (r_state == IDLE) && w_empty;

    assign busy                            = !w_empty || (r_state != IDLE);
    assign uart_tx                         = r_tx;
    assign data_memory_interface_read_data = r_rdata;

    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wptr[AW-1:0]] <= data_memory_interface_write_data[7:0];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_push_ok) r_wptr <= r_wptr + (AW+1)'(1);
            if (w_pop)     r_rptr <= r_rptr + (AW+1)'(1);
        end
    end

    // A fresh overflow in the same cycle as a status read wins over the clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_overflow <= 1'b0;
            r_rdata    <= '0;
        end else begin
            if (w_push_req && w_full && !w_pop) r_overflow <= 1'b1;
            else if (w_rd_status)               r_overflow <= 1'b0;

            if (w_rd_status)    r_rdata <= {29'b0, r_overflow, w_full, w_tx_idle};
            else if (w_rd_data) r_rdata <= '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= IDLE;
            r_baud    <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
            r_tx      <= 1'b1;
        end else begin
            r_state   <= w_state_next;
            r_baud    <= w_baud_next;
            r_bit_idx <= w_bit_idx_next;
            r_shift   <= w_shift_next;
            r_tx      <= w_tx_next;
        end
    end

    always_comb begin
        w_state_next   = r_state;
        w_baud_next    = r_baud;
        w_bit_idx_next = r_bit_idx;
        w_shift_next   = r_shift;
        w_pop          = 1'b0;
        case (r_state)
            IDLE: begin
                if (!w_empty) begin
                    w_pop        = 1'b1;
                    w_shift_next = r_mem[r_rptr[AW-1:0]];
                    w_baud_next  = BAUD_MAX;
                    w_state_next = START;
                end
            end
            START: begin
                if (r_baud == '0) begin
                    w_baud_next    = BAUD_MAX;
                    w_bit_idx_next = 3'd0;
                    w_state_next   = DATA;
                end else begin
                    w_baud_next = r_baud - BW'(1);
                end
            end
            DATA: begin
                if (r_baud == '0) begin
                    w_baud_next = BAUD_MAX;
                    if (r_bit_idx == 3'd7) begin
                        w_state_next = STOP;
                    end else begin
                        w_bit_idx_next = r_bit_idx + 3'd1;
                        w_shift_next   = {1'b0, r_shift[7:1]};
                    end
                end else begin
                    w_baud_next = r_baud - BW'(1);
                end
            end
            STOP: begin
                if (r_baud == '0) begin
                    if (!w_empty) begin
                        w_pop        = 1'b1;
                        w_shift_next = r_mem[r_rptr[AW-1:0]];
                        w_baud_next  = BAUD_MAX;
                        w_state_next = START;
                    end else begin
                        w_state_next = IDLE;
                    end
                end else begin
                    w_baud_next = r_baud - BW'(1);
                end
            end
            default: w_state_next = IDLE;
        endcase

        // Line level is registered from the next state, so it changes exactly at state edges.
        w_tx_next = 1'b1;
        if (w_state_next == START)     w_tx_next = 1'b0;
        else if (w_state_next == DATA) w_tx_next = w_shift_next[0];
    end

endmodule

// File: tb/tb_uart_console_tx.sv
// Scoreboard bench for uart_console_tx: characters expected on the line are queued at the
// store and popped by a line monitor that decodes each 8N1 frame.
`timescale 1ns/1ps

`ifndef WRITE
`define WRITE 1'b1
`endif
`ifndef READ
`define READ 1'b0
`endif

module tb_uart_console_tx;

    localparam logic [31:0] BASE = 32'h1000_0000;
    localparam logic [31:0] STAT = 32'h1000_0004;

    logic        clk = 1'b0;
    logic        clk_en = 1'b1;
    logic        reset = 1'b0;
    logic        en = 1'b0;
    logic        st = `READ;
    logic [31:0] addr = '0;
    logic [3:0]  mask = '0;
    logic [31:0] wdata = '0;
    logic [31:0] read_data;
    logic        uart_tx;
    logic        busy;

    int n_checks = 0;
    int n_err = 0;
    int cyc = 0;
    int frames = 0;
    int n_spurious = 0;
    int rst_cnt = 0;
    int last_cyc = 0;
    int starts[$];
    logic [7:0] exp_q[$];

    uart_console_tx #(.BASE_ADDRESS(BASE), .CLKS_PER_BIT(16), .FIFO_DEPTH(8)) dut (
        .clk                              (clk),
        .reset                            (reset),
        .data_memory_interface_enable     (en),
        .data_memory_interface_state      (st),
        .data_memory_interface_address    (addr),
        .data_memory_interface_frame_mask (mask),
        .data_memory_interface_write_data (wdata),
        .data_memory_interface_read_data  (read_data),
        .uart_tx                          (uart_tx),
        .busy                             (busy)
    );

    always #5 if (clk_en) clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge reset) rst_cnt = rst_cnt + 1;

    initial begin
        #1ms;
        $display("FAIL watchdog: got time %0t required completion", $time);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [3:0] m, input logic [7:0] d,
                             input bit expect_tx);
        @(negedge clk);
        en = 1'b1; st = `WRITE; addr = a; mask = m; wdata = {24'hA5A5A5, d};
        if (expect_tx) exp_q.push_back(d);
        @(posedge clk); #1;
        en = 1'b0;
        last_cyc = cyc;
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
        @(negedge clk);
        en = 1'b1; st = `READ; addr = a; mask = 4'hF;
        @(posedge clk); #1;
        en = 1'b0;
        d = read_data;
    endtask

    task automatic wait_busy_low(input int bound, output int c);
        int k = 0;
        while (busy !== 1'b0 && k < bound) begin
            @(posedge clk); #1;
            k++;
        end
        if (busy !== 1'b0) chk("timeout_busy", {31'h0, busy}, 32'h0);
        c = cyc;
    endtask

    task automatic wait_until(input int t);
        int k = 0;
        while (cyc < t && k < 5000) begin
            @(posedge clk); #1;
            k++;
        end
        if (cyc < t) chk("timeout_wait", cyc, t);
    endtask

    task automatic sample(output logic v, inout bit ab, input int snap);
        @(posedge clk); #1;
        if (!reset || rst_cnt != snap) ab = 1'b1;
        v = uart_tx;
    endtask

    // Line monitor: a low sample starts a frame; every slot must hold one level for 16 cycles.
    initial begin
        logic [7:0] b;
        logic       v;
        bit         ab;
        bit         ok;
        int         snap;
        forever begin
            @(posedge clk); #1;
            if (reset && uart_tx === 1'b0) begin
                snap = rst_cnt; ab = 1'b0; ok = 1'b1; b = '0;
                starts.push_back(cyc);
                for (int s = 1; s < 16 && !ab; s++) begin
                    sample(v, ab, snap);
                    if (v !== 1'b0) ok = 1'b0;
                end
                for (int i = 0; i < 8 && !ab; i++) begin
                    for (int s = 0; s < 16 && !ab; s++) begin
                        sample(v, ab, snap);
                        if (s == 0) b[i] = v;
                        else if (v !== b[i]) ok = 1'b0;
                    end
                end
                for (int s = 0; s < 16 && !ab; s++) begin
                    sample(v, ab, snap);
                    if (v !== 1'b1) ok = 1'b0;
                end
                if (!ab) begin
                    frames++;
                    if (exp_q.size() == 0) n_spurious++;
                    else chk("frame_byte", {24'h0, b}, {24'h0, exp_q.pop_front()});
                    chk("frame_shape", {31'h0, ok}, 32'h1);
                end
            end
        end
    end

    initial begin
        logic [31:0] r;
        int push_c, fall_c, f0, s0;

        repeat (3) @(posedge clk); #1;
        chk("rst_uart_tx", {31'h0, uart_tx}, 32'h1);
        chk("rst_busy", {31'h0, busy}, 32'h0);
        chk("rst_read_data", read_data, 32'h0);
        @(negedge clk) reset = 1'b1;
        @(posedge clk); #1;

        // single character 0x41
        f0 = frames; s0 = starts.size();
        bus_write(BASE, 4'b1000, 8'h41, 1'b1);
        push_c = last_cyc;
        wait_busy_low(400, fall_c);
        chk("t1_frames", frames - f0, 1);
        if (starts.size() > s0) begin
            chk("t1_latency", starts[s0] - push_c, 1);
            chk("t1_busy_fall", fall_c - starts[s0], 160);
        end

        // masked write and status-register write are ignored
        f0 = frames;
        bus_write(BASE, 4'b0001, 8'h55, 1'b0);
        bus_write(STAT, 4'b1111, 8'h66, 1'b0);
        repeat (40) @(posedge clk); #1;
        chk("t2_busy", {31'h0, busy}, 32'h0);
        chk("t2_frames", frames - f0, 0);
        bus_read(STAT, r);
        chk("t2_status", r, 32'h1);
        bus_read(BASE, r);
        chk("t2_data_read", r, 32'h0);

        // overflow: 1 in flight, 8 queued, 10th dropped
        f0 = frames;
        for (int i = 0; i < 10; i++) bus_write(BASE, 4'b1000, 8'h30 + 8'(i), i < 9);
        bus_read(STAT, r);
        chk("t3_status_ovf", r, 32'h6);
        bus_read(STAT, r);
        chk("t3_status_clr", r, 32'h2);
        wait_busy_low(2000, fall_c);
        chk("t3_frames", frames - f0, 9);
        chk("t3_queue_drained", exp_q.size(), 0);
        bus_read(STAT, r);
        chk("t3_status_idle", r, 32'h1);

        // back-to-back frames
        s0 = starts.size();
        bus_write(BASE, 4'b1000, 8'h00, 1'b1);
        bus_write(BASE, 4'b1000, 8'hFF, 1'b1);
        wait_busy_low(800, fall_c);
        chk("t4_starts", starts.size() - s0, 2);
        if (starts.size() > s0 + 1) begin
            chk("t4_gap", starts[s0+1] - starts[s0], 160);
            chk("t4_total", fall_c - starts[s0], 320);
        end

        // reset during DATA bit 3 with the clock stopped
        bus_write(BASE, 4'b1000, 8'h41, 1'b1);
        push_c = last_cyc;
        bus_write(BASE, 4'b1000, 8'h42, 1'b1);
        bus_write(BASE, 4'b1000, 8'h43, 1'b1);
        wait_until(push_c + 1 + 16 + 48 + 5);
        clk_en = 1'b0;
        reset = 1'b0;
        #2;
        chk("t5_rst_uart_tx", {31'h0, uart_tx}, 32'h1);
        chk("t5_rst_busy", {31'h0, busy}, 32'h0);
        chk("t5_rst_read_data", read_data, 32'h0);
        exp_q.delete();
        #20;
        reset = 1'b1;
        #3;
        clk_en = 1'b1;
        bus_read(STAT, r);
        chk("t5_status", r, 32'h1);
        f0 = frames;
        repeat (200) @(posedge clk); #1;
        chk("t5_no_residual", frames - f0, 0);
        chk("t5_busy", {31'h0, busy}, 32'h0);

        // push while full in the same cycle as the stop-end pop
        f0 = frames; s0 = starts.size();
        bus_write(BASE, 4'b1000, 8'hA0, 1'b1);
        push_c = last_cyc;
        for (int i = 1; i < 9; i++) bus_write(BASE, 4'b1000, 8'hA0 + 8'(i), 1'b1);
        wait_until(push_c + 160);
        bus_write(BASE, 4'b1000, 8'hA9, 1'b1);
        chk("t6_push_edge", last_cyc - push_c, 161);
        bus_read(STAT, r);
        chk("t6_status", r, 32'h2);
        wait_busy_low(2500, fall_c);
        chk("t6_frames", frames - f0, 10);
        chk("t6_queue_drained", exp_q.size(), 0);
        if (starts.size() > s0 + 1) chk("t6_second_start", starts[s0+1] - push_c, 161);
        bus_read(STAT, r);
        chk("t6_status_end", r, 32'h1);

        chk("spurious_frames", n_spurious, 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
